// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM states and default widths/constants.
package mips_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam int unsigned DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

endpackage : mips_pkg

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; flush wins over push and clears the queue outright.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule : fetch_fifo

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch front end: owns the fetch PC, drives the I-cache port and
// buffers fetched words in a prefetch queue; redirects during a miss wait for the old access.
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 30,
    parameter int unsigned       DATA_W   = INSTR_W,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W+1:0] RESET_PC = (ADDR_W+2)'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ICACHE_ren,
    output logic                ICACHE_wen,
    output logic [ADDR_W-1:0]   ICACHE_addr,
    output logic [DATA_W-1:0]   ICACHE_wdata,
    input  logic                ICACHE_stall,
    input  logic [DATA_W-1:0]   ICACHE_rdata,
    input  logic                redirect_valid,
    input  logic [ADDR_W+1:0]   redirect_pc,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_instr,
    output logic [ADDR_W+1:0]   out_pc4,
    input  logic                out_ready
);

    localparam int unsigned PC_W    = ADDR_W + 2;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = PC_W + DATA_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] saved_pc_q, saved_pc_d;

    logic               push, pop, flush, complete;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ADDR_W-1:0]  redirect_word;
    logic               unused_pc_bits;

    // PCs are word-aligned, so the fetch PC is tracked as a word address.
    assign redirect_word  = redirect_pc[PC_W-1:2];
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Request depends only on registered state so decode stalls cannot reach the cache.
    assign ICACHE_ren   = (state_q == DRAIN) || (fifo_count != CNT_W'(DEPTH));
    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = '0;
    assign ICACHE_addr  = fpc_q;

    assign complete   = ICACHE_ren && !ICACHE_stall;
    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid && out_ready;
    assign fifo_wdata = {fpc_q + ADDR_W'(1), 2'b00, ICACHE_rdata};
    assign out_pc4    = fifo_head[ENTRY_W-1:DATA_W];
    assign out_instr  = fifo_head[DATA_W-1:0];

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        saved_pc_d = saved_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (ICACHE_ren && ICACHE_stall) begin
                        // Hold addr/ren until the outstanding miss completes.
                        saved_pc_d = redirect_word;
                        state_d    = DRAIN;
                    end else begin
                        fpc_d = redirect_word;
                    end
                end else if (complete) begin
                    push  = 1'b1;
                    fpc_d = fpc_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    saved_pc_d = redirect_word;
                end
                if (complete) begin
                    fpc_d   = redirect_valid ? redirect_word : saved_pc_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            fpc_q      <= RESET_PC[PC_W-1:2];
            saved_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            saved_pc_q <= saved_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (fifo_wdata),
        .head  (fifo_head),
        .count (fifo_count)
    );

endmodule : mips_fetch_unit

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Parametrised instruction-fetch front end for the MIPS pipeline: owns the fetch PC, drives the I-cache port and buffers fetched words in a DEPTH-entry prefetch queue so fetch continues while decode stalls. Replaces the single IF/ID latch. Handles branch/jump redirects with queue flush, including redirects that arrive during an I-cache miss.

## Interface
- ADDR_W, 30: I-cache word-address width; byte PC is ADDR_W+2 bits.
- DATA_W, 32: instruction width.
- DEPTH, 4: prefetch queue entries; power of two, ≥2.
- RESET_PC, 0: byte PC loaded at reset; bits [1:0] are 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- ICACHE_ren  out  1  read request.
- ICACHE_wen  out  1  tied 0.
- ICACHE_addr  out  ADDR_W  word address, equal to fpc[ADDR_W+1:2].
- ICACHE_wdata  out  DATA_W  tied 0.
- ICACHE_stall  in  1  miss in progress; access completes in a cycle with ren=1 and stall=0.
- ICACHE_rdata  in  DATA_W  valid in the completing cycle.
- redirect_valid  in  1  taken branch/jump/jr from ID.
- redirect_pc  in  ADDR_W+2  target byte address.
- out_valid  out  1  queue head valid.
- out_instr  out  DATA_W  head instruction.
- out_pc4  out  ADDR_W+2  head PC+4.
- out_ready  in  1  decode accepts head (not stalled).

## Operation
- State: fpc, queue (rd_ptr, wr_ptr, count, width $clog2(DEPTH)+1), FSM {RUN, DRAIN}, saved_pc.
- ICACHE_ren = (state==DRAIN) | (count != DEPTH). Uses registered count only; no out_ready→ren path.
- complete = ICACHE_ren & ~ICACHE_stall.
- pop = out_valid & out_ready; out_valid = (count != 0); out_instr/out_pc4 = queue head.
- RUN, no redirect: on complete, push {fpc+4, ICACHE_rdata}; fpc <= fpc+4. Push and pop in the same cycle leaves count unchanged.
- RUN, redirect_valid with ICACHE_stall=0 or ren=0: flush the queue (count 0, pointers equal), discard any completing data, fpc <= redirect_pc. The state stays RUN.
- RUN, redirect_valid while ren=1 and ICACHE_stall=1: saved_pc <= redirect_pc, flush the queue, go to DRAIN. addr/ren are held so the cache protocol is not violated.
- DRAIN: ren=1, addr = old fpc, no pushes. A further redirect overwrites saved_pc. On complete: discard data, fpc <= saved_pc (or redirect_pc if a redirect arrives that cycle), go to RUN.
- A pop in a redirect cycle counts as delivered. All other entries are flushed.
- PC arithmetic is modulo 2^(ADDR_W+2). Pointers wrap modulo DEPTH.
- ICACHE_stall is ignored when ren=0.

## Timing
- After the reset edge: fpc=RESET_PC, count=0, state=RUN, out_valid=0, ICACHE_ren=1, ICACHE_addr=RESET_PC>>2. The queue contents are don't-care.
- Hit-to-output latency is 1: data completing at cycle t is at the head at t+1 when the queue was empty.
- Sustained throughput is 1 instruction/cycle with zero-stall cache and out_ready=1.
- Redirect at t with no miss: addr=redirect_pc>>2 at t+1. The earliest out_valid for the target is t+2.
- Redirect during a miss: the target address appears the cycle after the old access completes.
- rst asserted mid-miss or in DRAIN: reset state at the next edge, saved_pc is dropped, and a new request to RESET_PC starts.

## Structure
- Shared package mips_pkg: fetch FSM enum (RUN, DRAIN), default RESET_PC, instruction-width constant.
- Sub-module fetch_fifo: synchronous FIFO (DEPTH, width DATA_W+ADDR_W+2) with push, pop, flush, count, head output. Flush has priority over push; pop is evaluated on pre-flush contents.

## Test plan
- Reset, zero-stall cache returning addr as data, out_ready=1 → out_pc4 = 4, 8, 12… one per cycle from the second cycle after reset; out_instr matches.
- out_ready=0 for 10 cycles, DEPTH=4 → exactly 4 fetches (addr 0..3), then ren=0. Releasing out_ready drains 4 entries in order, and fetch resumes at addr 4.
- Redirect to 0x100 with 3 entries queued → out_valid=0 next cycle, addr=0x40 next cycle, first out_pc4=0x104.
- Stall held 5 cycles on addr 8, redirect to 0x200 in stall cycle 2 → addr stays 8 until stall drops, that data is not queued, then addr=0x80.
- Two redirects during one miss (0x300 then 0x400) → only 0x400 is fetched after completion.
- rst pulsed during DRAIN and with a full queue → out_valid=0, addr=RESET_PC>>2 after the edge; no stale entry is ever output.
